// File: rtl/sd_audio_stream_ctrl.sv
// SD-card to audio FIFO streaming sequencer: issues 512-byte block reads when the FIFO has room
// and paces FIFO reads to the sample rate. Define LOOP_EN for seamless looped playback.
module sd_audio_stream_ctrl #(
    parameter int BLOCK_BYTES = 512,
    parameter int FIFO_DEPTH  = 1024,
    parameter int CNT_W       = 11,
    parameter int SAMPLE_DIV  = 3125
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             play_in,
    input  logic [31:0]      start_addr_in,
    input  logic [31:0]      end_addr_in,
    input  logic             sd_ready_in,
    input  logic             sd_byte_avail_in,
    input  logic [7:0]       sd_dout_in,
    output logic             sd_rd_out,
    output logic [31:0]      sd_addr_out,
    input  logic [CNT_W-1:0] fifo_count_in,
    input  logic             fifo_full_in,
    input  logic             fifo_empty_in,
    output logic             fifo_wr_en_out,
    output logic [7:0]       fifo_din_out,
    output logic             fifo_rd_en_out,
    output logic             done_out,
    output logic             overflow_out,
    output logic [7:0]       underrun_out,
    output logic [2:0]       state_dbg_out
);

    localparam int BC_W = $clog2(BLOCK_BYTES + 1);
    localparam int PC_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [BC_W-1:0]  BLOCK_LAST = BC_W'(BLOCK_BYTES);
    localparam logic [PC_W-1:0]  PACE_LAST  = PC_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] ROOM_LIMIT = CNT_W'(FIFO_DEPTH - BLOCK_BYTES);
    localparam logic [31:0]      ADDR_STEP  = 32'(BLOCK_BYTES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_ISSUE    = 3'd2,
        S_XFER     = 3'd3,
        S_NEXT     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            sd_rd_q, sd_rd_d;
    logic [31:0]     sd_addr_q, sd_addr_d;
    logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
    logic            avail_prev_q, avail_prev_d;
    logic            wr_en_q, wr_en_d;
    logic [7:0]      din_q, din_d;
    logic            rd_en_q, rd_en_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      underrun_q, underrun_d;
    logic [PC_W-1:0] pace_cnt_q, pace_cnt_d;

    logic            byte_edge;
    logic            pace_run;
    logic [31:0]     addr_sum;

    assign byte_edge = sd_byte_avail_in & ~avail_prev_q;
    assign addr_sum  = sd_addr_q + ADDR_STEP;

    // Pacer also runs in DONE so the FIFO keeps draining after the last block.
    assign pace_run  = play_in && (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        sd_rd_d      = sd_rd_q;
        sd_addr_d    = sd_addr_q;
        byte_cnt_d   = byte_cnt_q;
        avail_prev_d = sd_byte_avail_in;
        wr_en_d      = 1'b0;
        din_d        = din_q;
        overflow_d   = overflow_q;

        case (state_q)
            S_IDLE: begin
                sd_rd_d = 1'b0;
                if (play_in) begin
                    sd_addr_d = start_addr_in;
                    state_d   = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (!play_in) begin
                    state_d = S_IDLE;
                end else if (sd_ready_in && (fifo_count_in <= ROOM_LIMIT)) begin
                    sd_rd_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The card drops ready once it has latched the read command.
                byte_cnt_d = '0;
                if (!sd_ready_in) begin
                    sd_rd_d = 1'b0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (byte_edge && (byte_cnt_q != BLOCK_LAST)) begin
                    wr_en_d    = 1'b1;
                    din_d      = sd_dout_in;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (fifo_full_in) begin
                        overflow_d = 1'b1;
                    end
                end
                if ((byte_cnt_q == BLOCK_LAST) && sd_ready_in) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (addr_sum == end_addr_in) begin
`ifdef LOOP_EN
                    if (play_in) begin
                        sd_addr_d = start_addr_in;
                        state_d   = S_WAIT_RDY;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_DONE;
`endif
                end else begin
                    sd_addr_d = addr_sum;
                    state_d   = play_in ? S_WAIT_RDY : S_IDLE;
                end
            end
            S_DONE: begin
                if (!play_in) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                sd_rd_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        pace_cnt_d = pace_cnt_q;
        rd_en_d    = 1'b0;
        underrun_d = underrun_q;
        if (!pace_run) begin
            pace_cnt_d = '0;
        end else if (pace_cnt_q == PACE_LAST) begin
            pace_cnt_d = '0;
            if (!fifo_empty_in) begin
                rd_en_d = 1'b1;
            end else if (underrun_q != 8'hFF) begin
                underrun_d = underrun_q + 8'd1;
            end
        end else begin
            pace_cnt_d = pace_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            sd_rd_q      <= 1'b0;
            sd_addr_q    <= '0;
            byte_cnt_q   <= '0;
            avail_prev_q <= 1'b0;
            wr_en_q      <= 1'b0;
            din_q        <= '0;
            rd_en_q      <= 1'b0;
            overflow_q   <= 1'b0;
            underrun_q   <= '0;
            pace_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sd_rd_q      <= sd_rd_d;
            sd_addr_q    <= sd_addr_d;
            byte_cnt_q   <= byte_cnt_d;
            avail_prev_q <= avail_prev_d;
            wr_en_q      <= wr_en_d;
            din_q        <= din_d;
            rd_en_q      <= rd_en_d;
            overflow_q   <= overflow_d;
            underrun_q   <= underrun_d;
            pace_cnt_q   <= pace_cnt_d;
        end
    end

    assign sd_rd_out      = sd_rd_q;
    assign sd_addr_out    = sd_addr_q;
    assign fifo_wr_en_out = wr_en_q;
    assign fifo_din_out   = din_q;
    assign fifo_rd_en_out = rd_en_q;
    assign done_out       = (state_q == S_DONE);
    assign overflow_out   = overflow_q;
    assign underrun_out   = underrun_q;
    assign state_dbg_out  = state_q;

endmodule

// File: tb/tb_sd_audio_stream_ctrl.sv
// Self-checking bench for sd_audio_stream_ctrl: a behavioural SD card, an expected byte queue,
// and an arithmetic model of block addresses and sample pacing.
module tb_sd_audio_stream_ctrl;

    localparam int BLOCK = 512;
    localparam int DIV   = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        play_in;
    logic [31:0] start_addr_in;
    logic [31:0] end_addr_in;
    logic        sd_ready_in;
    logic        sd_byte_avail_in;
    logic [7:0]  sd_dout_in;
    logic        sd_rd_out;
    logic [31:0] sd_addr_out;
    logic [10:0] fifo_count_in;
    logic        fifo_full_in;
    logic        fifo_empty_in;
    logic        fifo_wr_en_out;
    logic [7:0]  fifo_din_out;
    logic        fifo_rd_en_out;
    logic        done_out;
    logic        overflow_out;
    logic [7:0]  underrun_out;
    logic [2:0]  state_dbg_out;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [7:0] exp_q[$];

    sd_audio_stream_ctrl #(
        .BLOCK_BYTES(BLOCK), .FIFO_DEPTH(1024), .CNT_W(11), .SAMPLE_DIV(DIV)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .play_in(play_in),
        .start_addr_in(start_addr_in), .end_addr_in(end_addr_in),
        .sd_ready_in(sd_ready_in), .sd_byte_avail_in(sd_byte_avail_in), .sd_dout_in(sd_dout_in),
        .sd_rd_out(sd_rd_out), .sd_addr_out(sd_addr_out),
        .fifo_count_in(fifo_count_in), .fifo_full_in(fifo_full_in), .fifo_empty_in(fifo_empty_in),
        .fifo_wr_en_out(fifo_wr_en_out), .fifo_din_out(fifo_din_out), .fifo_rd_en_out(fifo_rd_en_out),
        .done_out(done_out), .overflow_out(overflow_out), .underrun_out(underrun_out),
        .state_dbg_out(state_dbg_out)
    );

    // Clock and watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // Driver tasks
    task automatic step();
        @(negedge clk_in);
    endtask

    // Advance one cycle and match any FIFO write against the expected byte queue.
    task automatic step_mon(inout int wr_seen, inout int data_err);
        logic [7:0] e;
        @(negedge clk_in);
        if (fifo_wr_en_out) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                data_err++;
            end else begin
                e = exp_q.pop_front();
                if (fifo_din_out !== e) data_err++;
            end
        end
    endtask

    task automatic do_reset();
        rst_in           = 1'b1;
        play_in          = 1'b0;
        start_addr_in    = 32'd0;
        end_addr_in      = 32'd1024;
        sd_ready_in      = 1'b1;
        sd_byte_avail_in = 1'b0;
        sd_dout_in       = 8'd0;
        fifo_count_in    = 11'd0;
        fifo_full_in     = 1'b0;
        fifo_empty_in    = 1'b0;
        exp_q.delete();
        repeat (2) step();
        rst_in = 1'b0;
    endtask

    // Behaves as the card for one block: waits for the read, checks its address, streams BLOCK bytes.
    task automatic sd_block(input logic [31:0] exp_addr, input int drop_at, input int hold_lo,
                            input int hold_hi, output int wr_seen, output int data_err);
        int waited;
        int hold;
        logic [7:0] b;
        wr_seen  = 0;
        data_err = 0;
        waited   = 0;
        while (!sd_rd_out && waited < 3000) begin
            step_mon(wr_seen, data_err);
            waited++;
        end
        chk_cnt++;
        if (sd_rd_out !== 1'b1) begin
            $display("FAIL rd_issue: sd_rd_out=%b, expected 1 within 3000 cycles", sd_rd_out);
            return;
        end
        pass_cnt++;
        chk_cnt++;
        if (sd_addr_out !== exp_addr) $display("FAIL rd_addr: sd_addr_out=%h, expected %h", sd_addr_out, exp_addr);
        else pass_cnt++;
        sd_ready_in = 1'b0;
        step_mon(wr_seen, data_err);
        chk_cnt++;
        if (sd_rd_out !== 1'b0) $display("FAIL rd_release: sd_rd_out=%b, expected 0", sd_rd_out);
        else pass_cnt++;
        for (int i = 0; i < BLOCK; i++) begin
            hold = $urandom_range(hold_hi, hold_lo);
            b = 8'($urandom);
            sd_dout_in = b;
            sd_byte_avail_in = 1'b1;
            exp_q.push_back(b);
            step_mon(wr_seen, data_err);
            sd_dout_in = ~b;
            for (int h = 1; h < hold; h++) step_mon(wr_seen, data_err);
            sd_byte_avail_in = 1'b0;
            if (i == drop_at) play_in = 1'b0;
            step_mon(wr_seen, data_err);
        end
        sd_ready_in = 1'b1;
        repeat (3) step_mon(wr_seen, data_err);
    endtask

    // Scenario tasks
    task automatic test_reset();
        rst_in = 1'b1;
        play_in = 1'b1;
        sd_ready_in = 1'b1;
        sd_byte_avail_in = 1'b1;
        fifo_empty_in = 1'b1;
        repeat (3) step();
        chk_cnt++;
        if ({sd_rd_out, fifo_wr_en_out, fifo_rd_en_out, done_out, overflow_out} !== 5'b0)
            $display("FAIL reset_flags: rd,wr,rd_en,done,ovf=%b, expected 00000",
                     {sd_rd_out, fifo_wr_en_out, fifo_rd_en_out, done_out, overflow_out});
        else pass_cnt++;
        chk_cnt++;
        if (sd_addr_out !== 32'd0) $display("FAIL reset_addr: %h, expected 0", sd_addr_out);
        else pass_cnt++;
        chk_cnt++;
        if ({fifo_din_out, underrun_out} !== 16'd0)
            $display("FAIL reset_data: din=%h underrun=%0d, expected 0/0", fifo_din_out, underrun_out);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_basic_blocks();
        int ws, de, waited;
        do_reset();
        play_in = 1'b1;
        sd_block(32'd0, -1, 1, 1, ws, de);
        chk_cnt++;
        if (ws !== BLOCK) $display("FAIL blk0_wr_count: %0d writes, expected %0d", ws, BLOCK);
        else pass_cnt++;
        chk_cnt++;
        if (de !== 0) $display("FAIL blk0_data: %0d bad bytes, expected 0", de);
        else pass_cnt++;
        sd_block(32'd512, -1, 3, 3, ws, de);
        chk_cnt++;
        if (ws !== BLOCK || de !== 0)
            $display("FAIL blk1_hold3: writes=%0d bad=%0d, expected %0d/0", ws, de, BLOCK);
        else pass_cnt++;
`ifdef LOOP_EN
        sd_block(32'd0, -1, 1, 2, ws, de);
        chk_cnt++;
        if (ws !== BLOCK || de !== 0)
            $display("FAIL loop_blk: writes=%0d bad=%0d, expected %0d/0", ws, de, BLOCK);
        else pass_cnt++;
`else
        chk_cnt++;
        if (done_out !== 1'b1) $display("FAIL done_set: done_out=%b, expected 1", done_out);
        else pass_cnt++;
        chk_cnt++;
        if (sd_addr_out !== 32'd512) $display("FAIL done_addr: %h, expected 00000200", sd_addr_out);
        else pass_cnt++;
        waited = 0;
        repeat (40) begin
            step();
            if (sd_rd_out) waited++;
        end
        chk_cnt++;
        if (waited !== 0) $display("FAIL done_no_read: sd_rd_out high %0d cycles, expected 0", waited);
        else pass_cnt++;
        play_in = 1'b0;
        step();
        step();
        chk_cnt++;
        if (done_out !== 1'b0) $display("FAIL done_clear: done_out=%b, expected 0", done_out);
        else pass_cnt++;
`endif
        chk_cnt++;
        if (overflow_out !== 1'b0) $display("FAIL no_overflow: overflow_out=%b, expected 0", overflow_out);
        else pass_cnt++;
    endtask

    // Addresses wrap through 2^32; model is start + k*BLOCK in 32-bit arithmetic.
    task automatic test_wrap();
        int ws, de;
        logic [31:0] s;
        do_reset();
        s = 32'hFFFF_FE00;
        start_addr_in = s;
        end_addr_in = s + 32'(2 * BLOCK);
        play_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sd_block(s + 32'(k * BLOCK), -1, 1, 3, ws, de);
            chk_cnt++;
            if (ws !== BLOCK || de !== 0)
                $display("FAIL wrap_blk%0d: writes=%0d bad=%0d, expected %0d/0", k, ws, de, BLOCK);
            else pass_cnt++;
        end
`ifdef LOOP_EN
        sd_block(s, -1, 1, 1, ws, de);
        chk_cnt++;
        if (ws !== BLOCK) $display("FAIL wrap_loop: writes=%0d, expected %0d", ws, BLOCK);
        else pass_cnt++;
`else
        chk_cnt++;
        if (done_out !== 1'b1 || sd_addr_out !== s + 32'(BLOCK))
            $display("FAIL wrap_done: done=%b addr=%h, expected 1/%h", done_out, sd_addr_out, s + 32'(BLOCK));
        else pass_cnt++;
`endif
    endtask

    task automatic test_fifo_gate();
        int hits;
        do_reset();
        fifo_count_in = 11'd600;
        play_in = 1'b1;
        hits = 0;
        repeat (20) begin
            step();
            if (sd_rd_out) hits++;
        end
        fifo_count_in = 11'd513;
        repeat (10) begin
            step();
            if (sd_rd_out) hits++;
        end
        chk_cnt++;
        if (hits !== 0) $display("FAIL gate_hold: sd_rd_out high %0d cycles, expected 0", hits);
        else pass_cnt++;
        fifo_count_in = 11'd512;
        step();
        chk_cnt++;
        if (sd_rd_out !== 1'b1) $display("FAIL gate_open: sd_rd_out=%b, expected 1", sd_rd_out);
        else pass_cnt++;
    endtask

    task automatic test_play_drop_overflow();
        int ws, de, hits;
        do_reset();
        fifo_full_in = 1'b1;
        play_in = 1'b1;
        step();
        chk_cnt++;
        if (overflow_out !== 1'b0) $display("FAIL ovf_idle: overflow_out=%b, expected 0", overflow_out);
        else pass_cnt++;
        sd_block(32'd0, 99, 1, 2, ws, de);
        chk_cnt++;
        if (ws !== BLOCK || de !== 0)
            $display("FAIL drop_complete: writes=%0d bad=%0d, expected %0d/0", ws, de, BLOCK);
        else pass_cnt++;
        fifo_full_in = 1'b0;
        hits = 0;
        repeat (30) begin
            step();
            if (sd_rd_out) hits++;
        end
        chk_cnt++;
        if (hits !== 0) $display("FAIL drop_no_read: sd_rd_out high %0d cycles, expected 0", hits);
        else pass_cnt++;
        chk_cnt++;
        if (overflow_out !== 1'b1) $display("FAIL ovf_sticky: overflow_out=%b, expected 1", overflow_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int ws, de, waited;
        do_reset();
        ws = 0;
        de = 0;
        fifo_full_in = 1'b1;
        fifo_empty_in = 1'b1;
        play_in = 1'b1;
        waited = 0;
        while (!sd_rd_out && waited < 50) begin
            step();
            waited++;
        end
        sd_ready_in = 1'b0;
        step();
        for (int i = 0; i < 50; i++) begin
            sd_dout_in = 8'($urandom_range(255, 1));
            sd_byte_avail_in = 1'b1;
            exp_q.push_back(sd_dout_in);
            step_mon(ws, de);
            sd_byte_avail_in = 1'b0;
            step_mon(ws, de);
        end
        chk_cnt++;
        if (ws !== 50 || overflow_out !== 1'b1)
            $display("FAIL mid_pre: writes=%0d ovf=%b, expected 50/1", ws, overflow_out);
        else pass_cnt++;
        sd_dout_in = 8'hA5;
        sd_byte_avail_in = 1'b1;
        rst_in = 1'b1;
        step();
        chk_cnt++;
        if ({sd_rd_out, fifo_wr_en_out, fifo_rd_en_out, done_out, overflow_out} !== 5'b0 ||
            sd_addr_out !== 32'd0 || fifo_din_out !== 8'd0 || underrun_out !== 8'd0)
            $display("FAIL mid_reset: flags=%b addr=%h din=%h und=%0d, expected all 0",
                     {sd_rd_out, fifo_wr_en_out, fifo_rd_en_out, done_out, overflow_out},
                     sd_addr_out, fifo_din_out, underrun_out);
        else pass_cnt++;
        do_reset();
    endtask

    // Pacing model: once a read pulse is seen, ticks fall every DIV cycles after it.
    task automatic test_pacer();
        int waited, errs, pulses;
        do_reset();
        sd_ready_in = 1'b0;
        play_in = 1'b1;
        waited = 0;
        while (!fifo_rd_en_out && waited < 20) begin
            step();
            waited++;
        end
        chk_cnt++;
        if (fifo_rd_en_out !== 1'b1) $display("FAIL pace_start: rd_en=%b, expected 1 within 20 cycles", fifo_rd_en_out);
        else pass_cnt++;
        errs = 0;
        for (int k = 1; k <= 4 * DIV; k++) begin
            step();
            if (fifo_rd_en_out !== ((k % DIV) == 0)) errs++;
        end
        chk_cnt++;
        if (errs !== 0) $display("FAIL pace_period: %0d wrong cycles, expected 0", errs);
        else pass_cnt++;
        fifo_empty_in = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 3 * DIV; k++) begin
            step();
            if (fifo_rd_en_out) pulses++;
        end
        chk_cnt++;
        if (pulses !== 0 || underrun_out !== 8'd3)
            $display("FAIL underrun3: pulses=%0d underrun=%0d, expected 0/3", pulses, underrun_out);
        else pass_cnt++;
        fifo_empty_in = 1'b0;
        errs = 0;
        for (int k = 1; k <= DIV; k++) begin
            step();
            if (fifo_rd_en_out !== (k == DIV)) errs++;
        end
        chk_cnt++;
        if (errs !== 0) $display("FAIL pace_resume: %0d wrong cycles, expected 0", errs);
        else pass_cnt++;
        fifo_empty_in = 1'b1;
        repeat (300 * DIV) step();
        chk_cnt++;
        if (underrun_out !== 8'd255) $display("FAIL underrun_sat: underrun=%0d, expected 255", underrun_out);
        else pass_cnt++;
        fifo_empty_in = 1'b0;
        play_in = 1'b0;
        pulses = 0;
        repeat (3 * DIV) begin
            step();
            if (fifo_rd_en_out) pulses++;
        end
        chk_cnt++;
        if (pulses !== 0 || underrun_out !== 8'd255)
            $display("FAIL pace_stop: pulses=%0d underrun=%0d, expected 0/255", pulses, underrun_out);
        else pass_cnt++;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_basic_blocks();
        test_wrap();
        test_fifo_gate();
        test_play_drop_overflow();
        test_reset_mid();
        test_pacer();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
